alu_cmd_sequencer: RTL and testbench

//  Upstream/downstream wrapper for the combinational 4-bit ALU (top).
//  - Accepts (a, b, op) commands over a valid/ready handshake.
//  - Registers them onto the ALU inputs and holds them for one execute cycle.
//  - Captures the ALU result and flags, then holds them until a consumer takes them.
//  - Decouples the combinational ALU from the bus side of the design.

---
 rtl/alu_cmd_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command wrapper around a combinational ALU; SEQ_STICKY_FLAGS_EN adds sticky {err,un,of}.
// Latency: result valid one cycle after accept; a held result stalls new commands until res_ready.
module alu_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int OPW   = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OPW-1:0]   cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_of,
  input  logic             alu_un,
  input  logic             alu_err,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [3:0]       res_flags,
  output logic             busy,
  output logic [CNTW-1:0]  cmd_count
`ifdef SEQ_STICKY_FLAGS_EN
  ,
  output logic [2:0]       sticky_flags,
  input  logic             sticky_clr
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [3:0]       res_flags_q, res_flags_d;
  logic [CNTW-1:0]  cmd_count_q, cmd_count_d;
`ifdef SEQ_STICKY_FLAGS_EN
  logic [2:0]       sticky_q, sticky_d;
`endif

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    cmd_count_d = cmd_count_q;
    cmd_ready   = 1'b0;
`ifdef SEQ_STICKY_FLAGS_EN
    sticky_d    = sticky_clr ? 3'b000 : sticky_q;
`endif

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          alu_op_d = cmd_op;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = alu_out;
        res_flags_d = {alu_err, alu_un, alu_of, alu_zero};
`ifdef SEQ_STICKY_FLAGS_EN
        // A capture in the same cycle as a clear survives the clear.
        sticky_d    = sticky_d | {alu_err, alu_un, alu_of};
`endif
        state_d     = DONE;
      end
      DONE: begin
        cmd_ready = res_ready;
        if (res_ready) begin
          cmd_count_d = cmd_count_q + CNTW'(1);
          if (cmd_valid) begin
            alu_a_d  = cmd_a;
            alu_b_d  = cmd_b;
            alu_op_d = cmd_op;
            state_d  = EXEC;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) cmd_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      cmd_count_q <= '0;
`ifdef SEQ_STICKY_FLAGS_EN
      sticky_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      cmd_count_q <= cmd_count_d;
`ifdef SEQ_STICKY_FLAGS_EN
      sticky_q    <= sticky_d;
`endif
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_valid = (state_q == DONE);
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;
  assign busy      = (state_q != IDLE);
  assign cmd_count = cmd_count_q;
`ifdef SEQ_STICKY_FLAGS_EN
  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: stub ALU, vector table, scoreboard of expected results.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_a, cmd_b, cmd_op;
  logic [3:0] alu_a, alu_b, alu_op, alu_out;
  logic       alu_of, alu_un, alu_err, alu_zero;
  logic       res_valid, res_ready;
  logic [3:0] res_data, res_flags;
  logic       busy;
  logic [7:0] cmd_count;
`ifdef SEQ_STICKY_FLAGS_EN
  logic [2:0] sticky_flags;
  logic       sticky_clr;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] cur_data, cur_flags;
  logic [7:0] sb_q[$];
  logic [7:0] exp_cnt;

  typedef struct {
    logic [3:0] a, b, op, ed, ef;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_of(alu_of), .alu_un(alu_un),
    .alu_err(alu_err), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags),
    .busy(busy), .cmd_count(cmd_count)
`ifdef SEQ_STICKY_FLAGS_EN
    , .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
`endif
  );

  // Returns {out, err, un, of, zero}
  function automatic logic [7:0] model(input logic [3:0] a, b, op);
    logic [4:0] t;
    logic [3:0] o, f;
    o = 4'd0;
    f = 4'd0;
    if (op == 4'd0) begin
      t = {1'b0, a} + {1'b0, b};
      o = t[3:0];
      f[1] = t[4];
    end else if (op == 4'd1) begin
      t = {1'b0, a} - {1'b0, b};
      o = t[3:0];
      f[2] = t[4];
    end
    f[0] = (o == 4'd0);
    f[3] = (op > 4'd7);
    return {o, f};
  endfunction

  always_comb begin
    logic [7:0] r;
    r = model(alu_a, alu_b, alu_op);
    alu_out  = r[7:4];
    alu_err  = r[3];
    alu_un   = r[2];
    alu_of   = r[1];
    alu_zero = r[0];
  end

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Scoreboard: push on command handshake, pop on result handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      exp_cnt = 8'd0;
    end else begin
      check("cmd_count", cmd_count, exp_cnt);
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_result", 1, 0);
        end else begin
          logic [7:0] e;
          e = sb_q.pop_front();
          check("sb_res_data", res_data, e[7:4]);
          check("sb_res_flags", res_flags, e[3:0]);
        end
        exp_cnt = exp_cnt + 8'd1;
      end
      if (cmd_valid && cmd_ready) sb_q.push_back({cur_data, cur_flags});
    end
  end

  task automatic do_cmd(input logic [3:0] a, b, op, ed, ef);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    cur_data  = ed;
    cur_flags = ef;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!acc) check("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 20 && !idle; k++) begin
      @(negedge clk);
      idle = !busy;
    end
    if (!idle) check("idle_timeout", 0, 1);
  endtask

  initial begin
    vecs[0] = '{a: 4'd2,  b: 4'd3, op: 4'd0, ed: 4'd5,  ef: 4'b0000};
    vecs[1] = '{a: 4'd15, b: 4'd6, op: 4'd0, ed: 4'd5,  ef: 4'b0010};
    vecs[2] = '{a: 4'd2,  b: 4'd2, op: 4'd1, ed: 4'd0,  ef: 4'b0001};
    vecs[3] = '{a: 4'd3,  b: 4'd5, op: 4'd1, ed: 4'd14, ef: 4'b0100};
    vecs[4] = '{a: 4'd9,  b: 4'd0, op: 4'd0, ed: 4'd9,  ef: 4'b0000};
    vecs[5] = '{a: 4'd8,  b: 4'd8, op: 4'd0, ed: 4'd0,  ef: 4'b0011};
    vecs[6] = '{a: 4'd4,  b: 4'd1, op: 4'd9, ed: 4'd0,  ef: 4'b1001};

    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = 4'd0; cmd_b = 4'd0; cmd_op = 4'd0;
    cur_data = 4'd0; cur_flags = 4'd0; exp_cnt = 8'd0;
`ifdef SEQ_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_flags", res_flags, 0);
    check("rst_cmd_count", cmd_count, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Vector table with consumer always ready
    res_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ed, vecs[i].ef);
      @(negedge clk);
      check("exec_res_valid", res_valid, 0);
      check("exec_busy", busy, 1);
      check("exec_cmd_ready", cmd_ready, 0);
      check("exec_alu_a", alu_a, vecs[i].a);
      check("exec_alu_b", alu_b, vecs[i].b);
      check("exec_alu_op", alu_op, vecs[i].op);
      @(negedge clk);
      check("done_res_valid", res_valid, 1);
      check("done_res_data", res_data, vecs[i].ed);
      check("done_res_flags", res_flags, vecs[i].ef);
      wait_idle();
    end

    // Consumer stalls for 5 cycles while a new command is offered
    res_ready = 1'b0;
    do_cmd(4'd15, 4'd6, 4'd0, 4'd5, 4'b0010);
    @(negedge clk); @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_a = 4'(k); cmd_b = 4'd1; cmd_op = 4'd1;
      @(negedge clk);
      check("hold_res_valid", res_valid, 1);
      check("hold_res_data", res_data, 5);
      check("hold_res_flags", res_flags, 4'b0010);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle();

    // Back-to-back: handoff and new accept on the same edge
    res_ready = 1'b0;
    do_cmd(4'd2, 4'd3, 4'd0, 4'd5, 4'b0000);
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    cur_data = 4'd0; cur_flags = 4'b0001;
    cmd_a = 4'd2; cmd_b = 4'd2; cmd_op = 4'd1; cmd_valid = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    check("b2b_cmd_ready", cmd_ready, 1);
    check("b2b_res_valid", res_valid, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_exec_res_valid", res_valid, 0);
    check("b2b_exec_busy", busy, 1);
    check("b2b_exec_alu_op", alu_op, 1);
    wait_idle();

`ifdef SEQ_STICKY_FLAGS_EN
    @(posedge clk); #1; sticky_clr = 1'b1;
    @(posedge clk); #1; sticky_clr = 1'b0;
    @(negedge clk);
    check("sticky_cleared", sticky_flags, 3'b000);
    do_cmd(4'd15, 4'd6, 4'd0, 4'd5, 4'b0010);
    wait_idle();
    check("sticky_of", sticky_flags, 3'b001);
    do_cmd(4'd4, 4'd1, 4'd9, 4'd0, 4'b1001);
    sticky_clr = 1'b1;
    @(posedge clk); #1; sticky_clr = 1'b0;
    @(negedge clk);
    check("sticky_clr_and_set", sticky_flags, 3'b100);
    repeat (3) @(negedge clk);
    check("sticky_held", sticky_flags, 3'b100);
    @(posedge clk); #1; sticky_clr = 1'b1;
    @(posedge clk); #1; sticky_clr = 1'b0;
    @(negedge clk);
    check("sticky_cleared2", sticky_flags, 3'b000);
`endif

    // Reset while in EXEC
    res_ready = 1'b1;
    do_cmd(4'd2, 4'd3, 4'd0, 4'd5, 4'b0000);
    rst = 1'b1;
    @(negedge clk);
    check("rst_exec_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rst_exec_res_valid", res_valid, 0);
    check("rst_exec_busy", busy, 0);
    check("rst_exec_count", cmd_count, 0);
    check("rst_exec_cmd_ready_after", cmd_ready, 1);
    @(negedge clk);
    check("rst_exec_res_valid2", res_valid, 0);

    // Reset while in DONE
    res_ready = 1'b0;
    do_cmd(4'd15, 4'd6, 4'd0, 4'd5, 4'b0010);
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    check("rst_done_res_valid", res_valid, 0);
    check("rst_done_res_data", res_data, 0);
    check("rst_done_res_flags", res_flags, 0);
    check("rst_done_alu_a", alu_a, 0);
    check("rst_done_busy", busy, 0);
    check("rst_done_count", cmd_count, 0);

    // Counter wrap: 256 handoffs
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv, r;
      iv = 8'(i);
      r = model(iv[3:0], iv[7:4], {3'b000, iv[0]});
      do_cmd(iv[3:0], iv[7:4], {3'b000, iv[0]}, r[7:4], r[3:0]);
      wait_idle();
      if (i == 254) check("count_255", cmd_count, 255);
      if (i == 255) check("count_wrap", cmd_count, 0);
    end

    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
